// File: rtl/i2c_reg_bank_if.sv
// Register-bank side bus between an I2C slave front end and i2c_reg_bank.
// The master modport is the I2C slave / status source; slave is the register bank.
interface i2c_reg_bank_if #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned NUM_REGS = 16
);
   logic                         ptrLoad;
   logic [DATA_W-1:0]            dataIn;
   logic                         writeEn;
   logic                         readAck;
   logic [NUM_REGS*DATA_W-1:0]   statusIn;
   logic [DATA_W-1:0]            dataOut;
   logic [NUM_REGS*DATA_W-1:0]   ctrlOut;
   logic                         errOut;

   modport master (
      output ptrLoad, dataIn, writeEn, readAck, statusIn,
      input  dataOut, ctrlOut, errOut
   );

   modport slave (
      input  ptrLoad, dataIn, writeEn, readAck, statusIn,
      output dataOut, ctrlOut, errOut
   );
endinterface

// File: rtl/i2c_reg_bank.sv
// Pointer-addressed register bank behind an I2C slave, with read-only status slots.
// Define I2C_REGBANK_AUTOINC_EN to make writeEn/readAck advance the pointer.
module i2c_reg_bank #(
   parameter int unsigned          DATA_W   = 8,
   parameter int unsigned          NUM_REGS = 16,
   parameter int unsigned          PTR_W    = 8,
   parameter logic [NUM_REGS-1:0]  RO_MASK  = '0,
   parameter logic [DATA_W-1:0]    RST_VAL  = '0
) (
   input  logic          clk,
   input  logic          rst,
   i2c_reg_bank_if.slave bus
);

   localparam logic [PTR_W:0] LAST_IDX = (PTR_W+1)'(NUM_REGS - 1);

   logic [DATA_W-1:0]          regs_q [NUM_REGS];
   logic [DATA_W-1:0]          regs_d [NUM_REGS];
   logic [PTR_W-1:0]           ptr_q, ptr_d;
   logic [DATA_W-1:0]          data_out_q, data_out_d;
   logic                       err_q, err_d;
   logic                       wr_hit;
   logic [NUM_REGS*DATA_W-1:0] ctrl_flat;

   always_comb begin
      regs_d = regs_q;
      ptr_d  = ptr_q;
      err_d  = 1'b0;
      wr_hit = 1'b0;

      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (ptr_q == PTR_W'(i) && !RO_MASK[i]) begin
            wr_hit = 1'b1;
         end
      end

      if (bus.ptrLoad) begin
         ptr_d = bus.dataIn[PTR_W-1:0];
      end else begin
         if (bus.writeEn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
               if (ptr_q == PTR_W'(i) && !RO_MASK[i]) begin
                  regs_d[i] = bus.dataIn;
               end
            end
            err_d = !wr_hit;
         end
`ifdef I2C_REGBANK_AUTOINC_EN
         // Out-of-range pointers wrap straight to 0 rather than counting up.
         if (bus.writeEn || bus.readAck) begin
            if ({1'b0, ptr_q} >= LAST_IDX) begin
               ptr_d = '0;
            end else begin
               ptr_d = ptr_q + PTR_W'(1);
            end
         end
`endif
      end
   end

`ifndef I2C_REGBANK_AUTOINC_EN
   logic unused_read_ack;
   assign unused_read_ack = bus.readAck;
`endif

   always_comb begin
      data_out_d = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (ptr_q == PTR_W'(i)) begin
            data_out_d = RO_MASK[i] ? bus.statusIn[i*DATA_W +: DATA_W] : regs_q[i];
         end
      end
   end

   always_comb begin
      ctrl_flat = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (!RO_MASK[i]) begin
            ctrl_flat[i*DATA_W +: DATA_W] = regs_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RO_MASK[i] ? '0 : RST_VAL;
         end
         ptr_q      <= '0;
         data_out_q <= '0;
         err_q      <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         ptr_q      <= ptr_d;
         data_out_q <= data_out_d;
         err_q      <= err_d;
      end
   end

   assign bus.dataOut = data_out_q;
   assign bus.ctrlOut = ctrl_flat;
   assign bus.errOut  = err_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed bench for i2c_reg_bank: 16 x 8-bit bank, register 4 read-only, reset value A5.
// Expectations follow the pointer mode chosen by I2C_REGBANK_AUTOINC_EN.
module tb_i2c_reg_bank;
   localparam int unsigned DW = 8;
   localparam int unsigned NR = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   i2c_reg_bank_if #(.DATA_W(DW), .NUM_REGS(NR)) bus ();

   i2c_reg_bank #(
      .DATA_W  (DW),
      .NUM_REGS(NR),
      .PTR_W   (8),
      .RO_MASK (16'h0010),
      .RST_VAL (8'hA5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [DW-1:0] exp_regs [NR];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic p, input logic w, input logic r, input logic [DW-1:0] d);
      bus.ptrLoad = p;
      bus.writeEn = w;
      bus.readAck = r;
      bus.dataIn  = d;
      @(posedge clk);
      #1;
      bus.ptrLoad = 1'b0;
      bus.writeEn = 1'b0;
      bus.readAck = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < int'(NR); i++) exp_regs[i] = (i == 4) ? 8'h00 : 8'hA5;
   endtask

   task automatic chk_ctrl(input string tag);
      for (int i = 0; i < int'(NR); i++) begin
         chk($sformatf("%s.ctrl%0d", tag, i), 32'(bus.ctrlOut[i*DW +: DW]), 32'(exp_regs[i]));
      end
   endtask

   initial begin
      bus.ptrLoad  = 1'b0;
      bus.writeEn  = 1'b0;
      bus.readAck  = 1'b0;
      bus.dataIn   = '0;
      bus.statusIn = '0;
      for (int i = 0; i < int'(NR); i++) bus.statusIn[i*DW +: DW] = 8'hC0 + 8'(i);
      bus.statusIn[4*DW +: DW] = 8'h5C;

      // Reset overrides strobes held during reset
      rst = 1'b1;
      cyc(1'b1, 1'b1, 1'b1, 8'h09);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      model_reset();
      chk_ctrl("rst");
      chk("rst.dout", 32'(bus.dataOut), 32'h00);
      chk("rst.err", 32'(bus.errOut), 32'h0);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      chk("rst.dout_r0", 32'(bus.dataOut), 32'hA5);

      // Burst from pointer 0x0E
      cyc(1'b1, 1'b0, 1'b0, 8'h0E);
      cyc(1'b0, 1'b1, 1'b0, 8'h11);
      cyc(1'b0, 1'b1, 1'b0, 8'h22);
      cyc(1'b0, 1'b1, 1'b0, 8'h33);
`ifdef I2C_REGBANK_AUTOINC_EN
      exp_regs[14] = 8'h11; exp_regs[15] = 8'h22; exp_regs[0] = 8'h33;
`else
      exp_regs[14] = 8'h33;
`endif
      chk_ctrl("burst");
      chk("burst.err", 32'(bus.errOut), 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 8'h44);
`ifdef I2C_REGBANK_AUTOINC_EN
      exp_regs[1] = 8'h44;
`else
      exp_regs[14] = 8'h44;
`endif
      chk_ctrl("burst_ptr");

      // Read-only status register 4
      cyc(1'b1, 1'b0, 1'b0, 8'h04);
`ifdef I2C_REGBANK_AUTOINC_EN
      chk("ro.lat", 32'(bus.dataOut), 32'hA5);
`else
      chk("ro.lat", 32'(bus.dataOut), 32'h44);
`endif
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      chk("ro.dout", 32'(bus.dataOut), 32'h5C);
      cyc(1'b0, 1'b1, 1'b0, 8'hFF);
      chk("ro.err_hi", 32'(bus.errOut), 32'h1);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      chk("ro.err_lo", 32'(bus.errOut), 32'h0);
`ifdef I2C_REGBANK_AUTOINC_EN
      chk("ro.ptr", 32'(bus.dataOut), 32'hA5);
`else
      chk("ro.ptr", 32'(bus.dataOut), 32'h5C);
`endif
      chk_ctrl("ro");

      // Out-of-range pointer 0x20
      cyc(1'b1, 1'b0, 1'b0, 8'h20);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      chk("oor.dout", 32'(bus.dataOut), 32'h00);
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
`ifdef I2C_REGBANK_AUTOINC_EN
      chk("oor.wrap", 32'(bus.dataOut), 32'h33);
`else
      chk("oor.wrap", 32'(bus.dataOut), 32'h00);
`endif
      cyc(1'b1, 1'b0, 1'b0, 8'h20);
      cyc(1'b0, 1'b1, 1'b0, 8'h77);
      chk("oor.err_hi", 32'(bus.errOut), 32'h1);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      chk("oor.err_lo", 32'(bus.errOut), 32'h0);
      chk_ctrl("oor");

      // ptrLoad priority, then combined write+ack
      cyc(1'b1, 1'b1, 1'b1, 8'h03);
      chk("prio.err", 32'(bus.errOut), 32'h0);
      chk_ctrl("prio");
      cyc(1'b0, 1'b1, 1'b1, 8'h5A);
      exp_regs[3] = 8'h5A;
      chk("prio.wr_err", 32'(bus.errOut), 32'h0);
      chk_ctrl("prio_wr");
      cyc(1'b0, 1'b1, 1'b0, 8'h66);
`ifdef I2C_REGBANK_AUTOINC_EN
      chk("adv1.err", 32'(bus.errOut), 32'h1);
`else
      exp_regs[3] = 8'h66;
      chk("adv1.err", 32'(bus.errOut), 32'h0);
`endif
      chk_ctrl("adv1");

      // Three writes from pointer 2
      cyc(1'b1, 1'b0, 1'b0, 8'h02);
      cyc(1'b0, 1'b1, 1'b0, 8'h01);
      cyc(1'b0, 1'b1, 1'b0, 8'h02);
      cyc(1'b0, 1'b1, 1'b0, 8'h03);
`ifdef I2C_REGBANK_AUTOINC_EN
      exp_regs[2] = 8'h01; exp_regs[3] = 8'h02;
      chk("tri.err", 32'(bus.errOut), 32'h1);
`else
      exp_regs[2] = 8'h03;
      chk("tri.err", 32'(bus.errOut), 32'h0);
`endif
      chk_ctrl("tri");
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
`ifdef I2C_REGBANK_AUTOINC_EN
      chk("tri.dout", 32'(bus.dataOut), 32'hA5);
`else
      chk("tri.dout", 32'(bus.dataOut), 32'h03);
`endif

      // Reset in the middle of a burst
      cyc(1'b1, 1'b0, 1'b0, 8'h07);
      cyc(1'b0, 1'b1, 1'b0, 8'h12);
      exp_regs[7] = 8'h12;
      chk_ctrl("mid_pre");
      rst = 1'b1;
      cyc(1'b0, 1'b1, 1'b0, 8'h99);
      rst = 1'b0;
      model_reset();
      chk_ctrl("mid_rst");
      chk("mid.dout", 32'(bus.dataOut), 32'h00);
      chk("mid.err", 32'(bus.errOut), 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      chk("mid.dout_r0", 32'(bus.dataOut), 32'hA5);
      cyc(1'b0, 1'b1, 1'b0, 8'hBB);
      exp_regs[0] = 8'hBB;
      chk_ctrl("mid_wr");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
